// File: rtl/hex_scan_display.sv
// +----------------------------------------------------------------------------+
// | Module   : hex_scan_display                                                |
// | Desc     : Time-multiplexed hex display driver. It latches a value and      |
// |            scans its digits over one shared 7-segment bus.                 |
// |            Optional leading-zero blanking: define HEX_SCAN_LZB_EN.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module hex_scan_display #(
    parameter int DIGITS         = 4,
    parameter int DIVIDER        = 50000,
    parameter int GUARD          = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int                c_SLOT_W    = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int                c_IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(DIVIDER - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DIGITS - 1);
    localparam logic              c_OFF       = (SEG_ACTIVE_LOW != 0);

    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_dp_mask;
    logic [c_SLOT_W-1:0] r_slot;
    logic [c_IDX_W-1:0]  r_index;
    logic [6:0]          r_seg;
    logic                r_dp;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame;

    logic [3:0]          w_nibs [DIGITS];
    logic [DIGITS-1:0]   w_blank;
    logic [3:0]          w_nib;
    logic [6:0]          w_pat;
    logic                w_guard;
    logic                w_slot_wrap;
    logic                w_idx_wrap;
    logic [DIGITS-1:0]   w_onehot;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_nib
            assign w_nibs[k] = r_value[4*k +: 4];
        end
    endgenerate

`ifdef HEX_SCAN_LZB_EN
    // A digit is blank when it and every more significant nibble are zero.
    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_blank
            if (k == 0) begin : g_lsd
                assign w_blank[k] = 1'b0;
            end else begin : g_upper
                assign w_blank[k] = ~|r_value[4*DIGITS-1:4*k];
            end
        end
    endgenerate
`else
    assign w_blank = '0;
`endif

    assign w_nib       = w_nibs[r_index];
    assign w_guard     = (int'(r_slot) < GUARD);
    assign w_slot_wrap = (r_slot == c_SLOT_LAST);
    assign w_idx_wrap  = w_slot_wrap && (r_index == c_IDX_LAST);
    assign w_onehot    = DIGITS'(1) << r_index;

    always_comb begin
        w_pat = 7'b0000000;
        case (w_nib)
            4'h0: w_pat = 7'b0111111;
            4'h1: w_pat = 7'b0000110;
            4'h2: w_pat = 7'b1011011;
            4'h3: w_pat = 7'b1001111;
            4'h4: w_pat = 7'b1100110;
            4'h5: w_pat = 7'b1101101;
            4'h6: w_pat = 7'b1111101;
            4'h7: w_pat = 7'b0000111;
            4'h8: w_pat = 7'b1111111;
            4'h9: w_pat = 7'b1101111;
            4'hA: w_pat = 7'b1110111;
            4'hB: w_pat = 7'b1111100;
            4'hC: w_pat = 7'b0111001;
            4'hD: w_pat = 7'b1011110;
            4'hE: w_pat = 7'b1111001;
            4'hF: w_pat = 7'b1110001;
            default: w_pat = 7'b0000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_value   <= '0;
            r_dp_mask <= '0;
        end else if (load) begin
            r_value   <= value;
            r_dp_mask <= dp_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot  <= '0;
            r_index <= '0;
        end else begin
            r_slot <= w_slot_wrap ? '0 : r_slot + 1'b1;
            if (w_slot_wrap) begin
                r_index <= (r_index == c_IDX_LAST) ? '0 : r_index + 1'b1;
            end
        end
    end

    // Output stage reflects the counter/index state of the previous cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an    <= {DIGITS{c_OFF}};
            r_seg   <= {7{c_OFF}};
            r_dp    <= c_OFF;
            r_frame <= 1'b0;
        end else begin
            r_frame <= w_idx_wrap;
            if (w_guard) begin
                r_an  <= {DIGITS{c_OFF}};
                r_seg <= {7{c_OFF}};
                r_dp  <= c_OFF;
            end else begin
                r_an  <= w_onehot ^ {DIGITS{c_OFF}};
                r_seg <= (w_blank[r_index] ? 7'b0000000 : w_pat) ^ {7{c_OFF}};
                r_dp  <= r_dp_mask[r_index] ^ c_OFF;
            end
        end
    end

    assign seg   = r_seg;
    assign dp    = r_dp;
    assign an    = r_an;
    assign frame = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_hex_scan_display.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_hex_scan_display                                             |
// | Desc     : Directed, table-driven bench for hex_scan_display (4 digits,    |
// |            4-cycle slots, 1 guard cycle, active-low outputs).              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_hex_scan_display;

    localparam logic [6:0] c_OFF7 = 7'b1111111;
    localparam logic [6:0] c_ZERO = 7'b1000000;
`ifdef HEX_SCAN_LZB_EN
    localparam logic [6:0] c_LZ   = 7'b1111111;
`else
    localparam logic [6:0] c_LZ   = 7'b1000000;
`endif

    typedef struct {
        logic [15:0]      value;
        logic [3:0]       dpm;
        logic [3:0][6:0]  seg;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic        load;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame;

    int checks;
    int failures;
    vec_t vecs [8];

    hex_scan_display #(
        .DIGITS         (4),
        .DIVIDER        (4),
        .GUARD          (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .value   (value),
        .load    (load),
        .dp_mask (dp_mask),
        .seg     (seg),
        .dp      (dp),
        .an      (an),
        .frame   (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                       input logic e_dp, input logic e_frame);
        checks++;
        if (an !== e_an || seg !== e_seg || dp !== e_dp || frame !== e_frame) begin
            failures++;
            $display("FAIL %s: got an=%b seg=%b dp=%b frame=%b, want an=%b seg=%b dp=%b frame=%b",
                     name, an, seg, dp, frame, e_an, e_seg, e_dp, e_frame);
        end
    endtask

    task automatic wait_frame();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (frame === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_frame: got no frame in 40 cycles, want one within 16");
        end
    endtask

    // Sixteen cycles starting right after a frame pulse (or a reset edge).
    task automatic check16(input string name, input vec_t v);
        int slot;
        int d;
        for (int i = 0; i < 16; i++) begin
            step();
            slot = i % 4;
            d    = i / 4;
            if (slot < 1)
                chk(name, 4'b1111, c_OFF7, 1'b1, 1'b0);
            else
                chk(name, ~(4'b0001 << d), v.seg[d], ~v.dpm[d], (i == 15));
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m);
        value   = v;
        dp_mask = m;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0] = '{16'h12AF, 4'b0100, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}};
        vecs[1] = '{16'h0005, 4'b0000, {c_LZ, c_LZ, c_LZ, 7'b0010010}};
        vecs[2] = '{16'h00A0, 4'b1000, {c_LZ, c_LZ, 7'b0001000, c_ZERO}};
        vecs[3] = '{16'h0000, 4'b0000, {c_LZ, c_LZ, c_LZ, c_ZERO}};
        vecs[4] = '{16'h8D6E, 4'b1111, {7'b0000000, 7'b0100001, 7'b0000010, 7'b0000110}};
        vecs[5] = '{16'h47B0, 4'b0001, {7'b0011001, 7'b1111000, 7'b0000011, c_ZERO}};
        vecs[6] = '{16'h0C09, 4'b0010, {c_LZ, 7'b1000110, c_ZERO, 7'b0010000}};
        vecs[7] = '{16'h3000, 4'b0000, {7'b0110000, c_ZERO, c_ZERO, c_ZERO}};

        // Reset held with load active: outputs stay dark, nothing latched.
        rst_n   = 1'b0;
        load    = 1'b1;
        value   = 16'hFFFF;
        dp_mask = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_hold", 4'b1111, c_OFF7, 1'b1, 1'b0);
        end

        rst_n = 1'b1;
        load  = 1'b0;
        step();
        chk("post_reset_guard", 4'b1111, c_OFF7, 1'b1, 1'b0);

        // Load in digit 0 slot: new value appears one edge after the load edge.
        value   = 16'h0005;
        dp_mask = 4'b0000;
        load    = 1'b1;
        step();
        chk("load_edge_old", 4'b1110, c_ZERO, 1'b1, 1'b0);
        load  = 1'b0;
        value = 16'hFFFF;
        step();
        chk("load_latency_new", 4'b1110, 7'b0010010, 1'b1, 1'b0);
        step();
        chk("no_load_hold", 4'b1110, 7'b0010010, 1'b1, 1'b0);

        for (int v = 0; v < 8; v++) begin
            do_load(vecs[v].value, vecs[v].dpm);
            value = 16'hFFFF;
            wait_frame();
            check16($sformatf("scan_vec%0d", v), vecs[v]);
        end

        // Reset while digit 2 is being driven, then restart from digit 0.
        wait_frame();
        for (int i = 0; i < 10; i++) step();
        chk("digit2_active", 4'b1011, c_ZERO, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        chk("midscan_reset", 4'b1111, c_OFF7, 1'b1, 1'b0);
        rst_n = 1'b1;
        check16("restart_after_reset", vecs[3]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
